// File: rtl/uart_pkg.sv
// Shared definitions for the board-to-board UART receiver and transmitter.
// Holds frame constants, the receiver state type and the tick prescaler helper.
package uart_pkg;

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} rx_state_t;

   localparam int unsigned UART_DATA_BITS = 8;
   localparam int unsigned UART_OS_RATE   = 16;

   // System clocks per oversample tick, rounded to nearest.
   function automatic int unsigned clks_per_tick(input int unsigned clk_hz,
                                                 input int unsigned baud);
      return (clk_hz + baud * UART_OS_RATE / 2) / (baud * UART_OS_RATE);
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running oversample tick prescaler; tick is high for one clk at terminal count.
// restart realigns the count to 0 so the tick phase follows the start edge.
module uart_baud_tick #(
   parameter int unsigned CLKS_PER_TICK = 326
) (
   input  logic clk,
   input  logic reset_n,
   input  logic restart,
   output logic tick
);

   localparam int unsigned CW = $clog2(CLKS_PER_TICK);
   localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_TICK - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt <= '0;
      end else if (restart || cnt == CNT_MAX) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

   assign tick = (cnt == CNT_MAX);

endmodule

// File: rtl/uart_rx_os16.sv
// 8N1 serial receiver with 16x oversampling; presents each good character on parin
// with a one-clk char_receive strobe, or a one-clk frame_err on a low stop bit.
module uart_rx_os16
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_TICK = clks_per_tick(50_000_000, 9600),
   parameter int unsigned DATA_BITS     = UART_DATA_BITS,
   parameter int unsigned OS_RATE       = UART_OS_RATE
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 serin,
   output logic [DATA_BITS-1:0] parin,
   output logic                 char_receive,
   output logic                 frame_err,
   output logic                 busy
);

   localparam int unsigned OW = $clog2(OS_RATE);
   localparam int unsigned BW = $clog2(DATA_BITS + 1);
   localparam logic [OW-1:0] OS_HALF  = OW'(OS_RATE / 2 - 1);
   localparam logic [OW-1:0] OS_LAST  = OW'(OS_RATE - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

   rx_state_t            state;
   logic [1:0]           sync_q;
   logic                 rx_s;
   logic                 tick;
   logic                 restart;
   logic [OW-1:0]        os_cnt;
   logic [BW-1:0]        bit_cnt;
   logic [DATA_BITS-1:0] shreg;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q <= 2'b11;
      end else begin
         sync_q <= {sync_q[0], serin};
      end
   end

   assign rx_s    = sync_q[1];
   assign restart = (state == IDLE) && !rx_s;
   assign busy    = (state != IDLE);

   uart_baud_tick #(
      .CLKS_PER_TICK(CLKS_PER_TICK)
   ) u_baud_tick (
      .clk    (clk),
      .reset_n(reset_n),
      .restart(restart),
      .tick   (tick)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= IDLE;
         os_cnt       <= '0;
         bit_cnt      <= '0;
         shreg        <= '0;
         parin        <= '0;
         char_receive <= 1'b0;
         frame_err    <= 1'b0;
      end else begin
         char_receive <= 1'b0;
         frame_err    <= 1'b0;
         unique case (state)
            IDLE: begin
               if (!rx_s) begin
                  state  <= START;
                  os_cnt <= '0;
               end
            end
            START: begin
               if (tick) begin
                  if (os_cnt == OS_HALF) begin
                     os_cnt  <= '0;
                     bit_cnt <= '0;
                     // A start that has gone high again by mid-bit is a glitch.
                     state   <= rx_s ? IDLE : DATA;
                  end else begin
                     os_cnt <= os_cnt + OW'(1);
                  end
               end
            end
            DATA: begin
               if (tick) begin
                  if (os_cnt == OS_LAST) begin
                     shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
                     os_cnt  <= '0;
                     bit_cnt <= bit_cnt + BW'(1);
                     if (bit_cnt == BIT_LAST) begin
                        state <= STOP;
                     end
                  end else begin
                     os_cnt <= os_cnt + OW'(1);
                  end
               end
            end
            STOP: begin
               if (tick) begin
                  if (os_cnt == OS_LAST) begin
                     os_cnt <= '0;
                     if (rx_s) begin
                        parin        <= shreg;
                        char_receive <= 1'b1;
                        state        <= IDLE;
                     end else begin
                        frame_err <= 1'b1;
                        state     <= BREAK;
                     end
                  end else begin
                     os_cnt <= os_cnt + OW'(1);
                  end
               end
            end
            BREAK: begin
               // Hold off until the line idles so a stuck-low line is not a new start.
               if (rx_s) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx_os16.sv
// Self-checking bench for uart_rx_os16 with CLKS_PER_TICK=4 (64 clk per bit).
// A frame-level model predicts each strobe/error from the start-edge time and frame contents.
module tb_uart_rx_os16;

   localparam int BIT_CLK = 64;
   localparam int LAT     = 611;  // (8+1.5)*16 ticks * 4 clk + 3 clk
   localparam int TOL     = 4;    // +-1 tick

   typedef struct {
      int         lo;
      int         hi;
      bit         err;
      logic [7:0] data;
   } ev_t;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       serin = 1'b1;
   logic [7:0] parin;
   logic       char_receive;
   logic       frame_err;
   logic       busy;

   int         cyc = 0;
   int         tests = 0;
   int         fails = 0;
   bit         run_chk = 1'b0;
   bit         prev_pulse = 1'b0;
   int         last_good_cyc = 0;
   logic [7:0] model_parin = '0;
   ev_t        exp_q[$];

   uart_rx_os16 #(
      .CLKS_PER_TICK(4),
      .DATA_BITS    (8),
      .OS_RATE      (16)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .serin       (serin),
      .parin       (parin),
      .char_receive(char_receive),
      .frame_err   (frame_err),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      tests++;
      if (act !== expv) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) begin
         @(posedge clk);
      end
      #1;
   endtask

   // Drives one full frame starting now; leaves the line at the stop level.
   task automatic send_frame(input logic [7:0] d, input bit stop_ok, output int t0);
      ev_t ev;
      serin = 1'b0;
      t0 = cyc;
      ev.lo = t0 + LAT - TOL;
      ev.hi = t0 + LAT + TOL;
      ev.err = !stop_ok;
      ev.data = d;
      exp_q.push_back(ev);
      wait_clk(BIT_CLK);
      for (int i = 0; i < 8; i++) begin
         serin = d[i];
         wait_clk(BIT_CLK);
      end
      serin = stop_ok;
      wait_clk(BIT_CLK);
   endtask

   // Per-cycle compare against the frame-level model.
   always @(negedge clk) begin
      ev_t ev;
      bit  pulse;
      if (reset_n && run_chk) begin
         pulse = char_receive || frame_err;
         if (exp_q.size() > 0 && cyc > exp_q[0].hi) begin
            ev = exp_q.pop_front();
            tests++;
            fails++;
            $display("FAIL missing_pulse: got none expected err=%0d data=%0h by cycle %0d",
                     ev.err, ev.data, ev.hi);
         end
         if (pulse) begin
            tests++;
            if (exp_q.size() == 0) begin
               fails++;
               $display("FAIL unexpected_pulse: got char=%0b err=%0b expected none at cycle %0d",
                        char_receive, frame_err, cyc);
            end else begin
               ev = exp_q.pop_front();
               if (cyc < ev.lo || frame_err !== ev.err || char_receive === ev.err ||
                   (!ev.err && parin !== ev.data)) begin
                  fails++;
                  $display("FAIL pulse_match: got cyc=%0d char=%0b err=%0b parin=%0h expected cyc %0d..%0d err=%0b data=%0h",
                           cyc, char_receive, frame_err, parin, ev.lo, ev.hi, ev.err, ev.data);
               end
               if (!ev.err) begin
                  model_parin = ev.data;
                  last_good_cyc = cyc;
               end
            end
         end
         tests++;
         if (parin !== model_parin || (char_receive && frame_err) || (pulse && prev_pulse)) begin
            fails++;
            $display("FAIL cycle_check: got parin=%0h char=%0b err=%0b prev_pulse=%0b expected parin=%0h single pulses",
                     parin, char_receive, frame_err, prev_pulse, model_parin);
         end
         prev_pulse = pulse;
      end else begin
         prev_pulse = 1'b0;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int         t0;
      int         lat;
      logic [7:0] d;
      int         sel;

      // Reset, then idle line.
      wait_clk(5);
      chk("reset_busy", busy, 0);
      chk("reset_parin", parin, 0);
      chk("reset_char", char_receive, 0);
      chk("reset_ferr", frame_err, 0);
      reset_n = 1'b1;
      run_chk = 1'b1;
      wait_clk(2000);
      chk("idle_busy", busy, 0);
      chk("idle_parin", parin, 0);

      // Single frame 0xA5.
      send_frame(8'hA5, 1'b1, t0);
      chk("a5_parin", parin, 8'hA5);
      lat = last_good_cyc - t0;
      chk("a5_latency_ok", (lat >= LAT - TOL && lat <= LAT + TOL), 1);
      chk("a5_idle", busy, 0);

      // Back-to-back frames.
      send_frame(8'h00, 1'b1, t0);
      chk("b2b_00", parin, 8'h00);
      send_frame(8'hFF, 1'b1, t0);
      chk("b2b_ff", parin, 8'hFF);
      send_frame(8'h3C, 1'b1, t0);
      chk("b2b_3c", parin, 8'h3C);
      wait_clk(20);

      // Glitch.
      serin = 1'b0;
      wait_clk(20);
      serin = 1'b1;
      chk("glitch_busy", busy, 1);
      wait_clk(64);
      chk("glitch_idle", busy, 0);
      chk("glitch_parin", parin, 8'h3C);

      // Framing error, break, then a good frame.
      send_frame(8'h55, 1'b0, t0);
      wait_clk(100);
      chk("break_busy", busy, 1);
      chk("break_parin", parin, 8'h3C);
      wait_clk(100);
      serin = 1'b1;
      wait_clk(10);
      chk("break_exit", busy, 0);
      send_frame(8'h81, 1'b1, t0);
      chk("after_break_81", parin, 8'h81);
      wait_clk(10);

      // Async reset during data bit 4; remaining bits are all 1 so no frame forms.
      d = 8'hF3;
      send_start_partial: begin
         ev_t ev;
         serin = 1'b0;
         t0 = cyc;
         ev.lo = t0 + LAT - TOL;
         ev.hi = t0 + LAT + TOL;
         ev.err = 1'b0;
         ev.data = d;
         exp_q.push_back(ev);
         wait_clk(BIT_CLK);
         for (int i = 0; i < 4; i++) begin
            serin = d[i];
            wait_clk(BIT_CLK);
         end
         serin = d[4];
         wait_clk(10);
      end
      chk("pre_reset_busy", busy, 1);
      #2 reset_n = 1'b0;
      #1;
      chk("mid_reset_busy", busy, 0);
      chk("mid_reset_parin", parin, 0);
      chk("mid_reset_char", char_receive, 0);
      chk("mid_reset_ferr", frame_err, 0);
      exp_q.delete();
      model_parin = '0;
      wait_clk(3);
      reset_n = 1'b1;
      for (int i = 5; i < 8; i++) begin
         serin = d[i];
         wait_clk(BIT_CLK);
      end
      serin = 1'b1;
      wait_clk(2 * BIT_CLK);
      chk("post_reset_parin", parin, 0);
      chk("post_reset_idle", busy, 0);
      send_frame(8'h5A, 1'b1, t0);
      chk("post_reset_5a", parin, 8'h5A);

      // Randomized mix of good frames, framing errors and glitches.
      for (int k = 0; k < 24; k++) begin
         sel = $urandom_range(0, 9);
         d = 8'($urandom);
         if (sel < 6) begin
            send_frame(d, 1'b1, t0);
            if ($urandom_range(0, 1) == 1) wait_clk($urandom_range(1, 80));
         end else if (sel < 8) begin
            send_frame(d, 1'b0, t0);
            wait_clk($urandom_range(0, 200));
            serin = 1'b1;
            wait_clk($urandom_range(8, 40));
         end else begin
            serin = 1'b0;
            wait_clk($urandom_range(1, 20));
            serin = 1'b1;
            wait_clk(BIT_CLK);
         end
      end

      wait_clk(700);
      chk("queue_drained", exp_q.size(), 0);
      chk("final_idle", busy, 0);
      chk("final_parin", parin, model_parin);
      run_chk = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
